button_debounce_2ch: RTL and testbench

Two-channel push-button conditioner that sits directly upstream of the two-flop select/latch stage, which today clocks its flops straight off raw `ui_in[2]` and `ui_in[3]`. Each channel synchronises its asynchronous button input into `clk` and rejects bounce with a stability counter. It then presents a clean debounced level plus single-cycle rise and fall strobes. The downstream stage uses `btn_rise[n]` as a clock-enable on `clk` instead of using the button as a clock.

---
 rtl/button_debounce_2ch.sv | 77 +++++++
 tb/tb_button_debounce_2ch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_2ch.sv
// Two-channel push-button conditioner: per-channel synchroniser, stability-counter
// debounce, and registered single-cycle rise/fall strobes for use as clock enables.

module button_debounce_ch #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);
    // Terminal count; STABLE_CYCLES may equal 2^CNT_W, so STABLE_CYCLES-1 always fits.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (!en || s2 == level) begin
                // Any matching (or disabled) cycle discards the partial count.
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
                fall  <= ~s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module button_debounce_2ch #(
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] btn_raw,
    output logic [1:0] btn_level,
    output logic [1:0] btn_rise,
    output logic [1:0] btn_fall
);
    for (genvar i = 0; i < 2; i++) begin : g_ch
        button_debounce_ch #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .en   (en),
            .raw  (btn_raw[i]),
            .level(btn_level[i]),
            .rise (btn_rise[i]),
            .fall (btn_fall[i])
        );
    end
endmodule

// File: tb/tb_button_debounce_2ch.sv
// Self-checking bench for button_debounce_2ch: directed scenarios with fixed
// expectations, then randomized traffic against a streak-counting reference model.

module tb_button_debounce_2ch;
    localparam int STABLE = 4;
    localparam int CW     = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b1;
    logic [1:0] btn_raw = 2'b00;
    logic [1:0] btn_level, btn_rise, btn_fall;

    int tests = 0;
    int fails = 0;

    button_debounce_2ch #(.STABLE_CYCLES(STABLE), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .btn_raw  (btn_raw),
        .btn_level(btn_level),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall)
    );

    always #5 clk = ~clk;

    // Reference: raw goes through a 2-deep delay queue; a level flips once the
    // delayed value has disagreed with it on STABLE consecutive enabled edges.
    bit         mq[2][$];
    int         streak[2];
    logic [1:0] m_level = 2'b00, m_rise = 2'b00, m_fall = 2'b00;

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            bit sv;
            if (rst) begin
                mq[c].delete();
                mq[c].push_back(1'b0);
                mq[c].push_back(1'b0);
                streak[c] = 0;
                m_level[c] = 1'b0;
                m_rise[c]  = 1'b0;
                m_fall[c]  = 1'b0;
            end else begin
                sv = mq[c].pop_front();
                mq[c].push_back(btn_raw[c]);
                m_rise[c] = 1'b0;
                m_fall[c] = 1'b0;
                if (!en || sv == m_level[c]) begin
                    streak[c] = 0;
                end else begin
                    streak[c]++;
                    if (streak[c] == STABLE) begin
                        m_level[c] = sv;
                        m_rise[c]  = sv;
                        m_fall[c]  = ~sv;
                        streak[c]  = 0;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic [1:0] r);
        rst = 1'b1; en = 1'b1; btn_raw = r;
        tick(); tick();
        rst = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; btn_raw = 2'b11;
        repeat (3) begin
            tick();
            tests++;
            if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
                fails++;
                $display("FAIL reset_hold: got %b want 000000", {btn_level, btn_rise, btn_fall});
            end
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (btn_level !== (k >= 6 ? 2'b11 : 2'b00) || btn_rise !== (k == 6 ? 2'b11 : 2'b00)
                || btn_fall !== 2'b00) begin
                fails++;
                $display("FAIL reset_release edge %0d: got lvl=%b rise=%b fall=%b", k, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_clean_press();
        do_reset(2'b00);
        btn_raw = 2'b01;
        for (int k = 0; k <= 8; k++) begin
            tick();
            tests++;
            if (btn_level !== (k >= 5 ? 2'b01 : 2'b00) || btn_rise !== (k == 5 ? 2'b01 : 2'b00)
                || btn_fall !== 2'b00) begin
                fails++;
                $display("FAIL clean_press E%0d: got lvl=%b rise=%b fall=%b", k, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[7] = '{1, 1, 1, 0, 1, 1, 1};
        do_reset(2'b00);
        for (int i = 0; i < 17; i++) begin
            btn_raw[0] = (i < 7) ? pat[i] : 1'b0;
            tick();
            tests++;
            if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
                fails++;
                $display("FAIL bounce cyc %0d: got lvl=%b rise=%b fall=%b", i, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_release();
        do_reset(2'b10);
        tests++;
        if (btn_level !== 2'b10) begin
            fails++;
            $display("FAIL release_setup: got lvl=%b want 10", btn_level);
        end
        btn_raw = 2'b00;
        for (int k = 0; k <= 8; k++) begin
            tick();
            tests++;
            if (btn_level !== (k < 5 ? 2'b10 : 2'b00) || btn_fall !== (k == 5 ? 2'b10 : 2'b00)
                || btn_rise !== 2'b00) begin
                fails++;
                $display("FAIL release E%0d: got lvl=%b rise=%b fall=%b", k, btn_level, btn_rise, btn_fall);
            end
        end
    endtask

    task automatic test_enable_gating();
        do_reset(2'b00);
        btn_raw = 2'b01;
        repeat (3) tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
                fails++;
                $display("FAIL en_low cyc %0d: got lvl=%b rise=%b fall=%b", i, btn_level, btn_rise, btn_fall);
            end
        end
        en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests++;
            if (btn_level !== (k >= 4 ? 2'b01 : 2'b00) || btn_rise !== (k == 4 ? 2'b01 : 2'b00)) begin
                fails++;
                $display("FAIL en_return edge %0d: got lvl=%b rise=%b", k, btn_level, btn_rise);
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(2'b00);
        btn_raw = 2'b01;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        tests++;
        if (btn_level !== 2'b00 || btn_rise !== 2'b00) begin
            fails++;
            $display("FAIL mid_reset_hold: got lvl=%b rise=%b", btn_level, btn_rise);
        end
        rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            tests++;
            if (btn_level !== (k >= 6 ? 2'b01 : 2'b00) || btn_rise !== (k == 6 ? 2'b01 : 2'b00)) begin
                fails++;
                $display("FAIL mid_reset edge %0d: got lvl=%b rise=%b", k, btn_level, btn_rise);
            end
        end
    endtask

    task automatic test_random();
        do_reset(2'b00);
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < 2; c++)
                if ($urandom_range(0, 5) == 0) btn_raw[c] = ~btn_raw[c];
            en  = ($urandom_range(0, 19) != 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
            tests++;
            if (btn_level !== m_level || btn_rise !== m_rise || btn_fall !== m_fall
                || (btn_rise & btn_fall) !== 2'b00) begin
                fails++;
                $display("FAIL random cyc %0d: got lvl=%b rise=%b fall=%b want lvl=%b rise=%b fall=%b",
                         i, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
            end
        end
        rst = 1'b0;
        en  = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_enable_gating();
        test_mid_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
